// File: rtl/mem_ctrl_pkg.sv
// Shared constants and types for the 128x4 memory controller.
// Imported by the controller top and its arbiter.
package mem_ctrl_pkg;

  localparam int DEPTH = 128;
  localparam int AW    = 7;
  localparam int DW    = 4;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN
  } state_e;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] wmask;
  } req_t;

  function automatic req_t pick_req(
    input logic sel1,
    input req_t r0,
    input req_t r1
  );
    return sel1 ? r1 : r0;
  endfunction

endpackage

// File: rtl/mem_128x4_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter with a one-bit favour pointer.
// Pointer flips to the non-granted side after every grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (1'b1)
        req[0] & (~req[1] | ~ptr_q): gnt = 2'b01;
        req[1] & (~req[0] |  ptr_q): gnt = 2'b10;
        default:                     gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt[0]) ptr_d = 1'b1;
    if (gnt[1]) ptr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_128x4_ctrl.sv
// Dual-requester controller for an external 128x4 1R1W memory macro.
// Sweeps the array to zero after reset or clear_req, then arbitrates.
module mem_128x4_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic          clock,
  input  logic          reset,

  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  input  logic [DW-1:0] req0_wmask,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_data,

  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  input  logic [DW-1:0] req1_wmask,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_data,

  input  logic          clear_req,
  output logic          clear_busy,

  output logic [AW-1:0] R0_addr,
  output logic          R0_en,
  input  logic [DW-1:0] R0_data,

  output logic [AW-1:0] W0_addr,
  output logic          W0_en,
  output logic [DW-1:0] W0_data,
  output logic [DW-1:0] W0_mask
);

  state_e        state_q;
  state_e        state_d;
  logic [AW-1:0] cnt_q;
  logic [AW-1:0] cnt_d;
  logic [1:0]    rsp_vld_q;
  logic [1:0]    rsp_vld_d;
  logic          busy_q;
  logic          busy_d;

  logic          run;
  logic          clr;
  logic [1:0]    rd_req;
  logic [1:0]    wr_req;
  logic [1:0]    rd_gnt;
  logic [1:0]    wr_gnt;
  req_t          rq0;
  req_t          rq1;
  req_t          rsel;
  req_t          wsel;

  assign run = (state_q == ST_RUN);
  assign clr = (state_q == ST_CLEAR);

  assign rq0 = '{we: req0_we, addr: req0_addr,
                 wdata: req0_wdata, wmask: req0_wmask};
  assign rq1 = '{we: req1_we, addr: req1_addr,
                 wdata: req1_wdata, wmask: req1_wmask};

  assign rd_req = {req1_valid & ~req1_we,
                   req0_valid & ~req0_we};
  assign wr_req = {req1_valid &  req1_we,
                   req0_valid &  req0_we};

  // Reads and writes use separate arbiters so a read
  // and a write can both be granted in one cycle.
  rr_arb2 u_rd_arb (
    .clk   (clock),
    .rst_n (reset),
    .en    (run),
    .req   (rd_req),
    .gnt   (rd_gnt)
  );

  rr_arb2 u_wr_arb (
    .clk   (clock),
    .rst_n (reset),
    .en    (run),
    .req   (wr_req),
    .gnt   (wr_gnt)
  );

  assign req0_ready = rd_gnt[0] | wr_gnt[0];
  assign req1_ready = rd_gnt[1] | wr_gnt[1];

  assign rsel = pick_req(rd_gnt[1], rq0, rq1);
  assign wsel = pick_req(wr_gnt[1], rq0, rq1);

  always_comb begin
    R0_en   = |rd_gnt;
    R0_addr = rsel.addr;
    W0_en   = |wr_gnt;
    W0_addr = wsel.addr;
    W0_data = wsel.wdata;
    W0_mask = wsel.wmask;
    if (clr) begin
      W0_en   = 1'b1;
      W0_addr = cnt_q;
      W0_data = '0;
      W0_mask = '1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_CLEAR;
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) state_d = ST_RUN;
      end
      ST_RUN: if (clear_req) state_d = ST_CLEAR;
      default: state_d = ST_IDLE;
    endcase
    busy_d    = (state_d != ST_RUN);
    rsp_vld_d = rd_gnt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rsp_vld_q <= 2'b00;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rsp_vld_q <= rsp_vld_d;
      busy_q    <= busy_d;
    end
  end

  assign clear_busy = busy_q;

  assign rsp0_valid = rsp_vld_q[0];
  assign rsp1_valid = rsp_vld_q[1];
  assign rsp0_data  = rsp_vld_q[0] ? R0_data : '0;
  assign rsp1_data  = rsp_vld_q[1] ? R0_data : '0;

endmodule

// File: tb/tb_mem_128x4_ctrl.sv
// Directed bench for mem_128x4_ctrl with a write-first
// behavioural model of the external 128x4 macro.
module tb_mem_128x4_ctrl;

  logic       clock;
  logic       reset;
  logic       req0_valid, req0_ready, req0_we;
  logic [6:0] req0_addr;
  logic [3:0] req0_wdata, req0_wmask;
  logic       rsp0_valid;
  logic [3:0] rsp0_data;
  logic       req1_valid, req1_ready, req1_we;
  logic [6:0] req1_addr;
  logic [3:0] req1_wdata, req1_wmask;
  logic       rsp1_valid;
  logic [3:0] rsp1_data;
  logic       clear_req, clear_busy;
  logic [6:0] R0_addr;
  logic       R0_en;
  logic [3:0] R0_data;
  logic [6:0] W0_addr;
  logic       W0_en;
  logic [3:0] W0_data, W0_mask;

  int n_chk  = 0;
  int n_fail = 0;

  mem_128x4_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_wmask (req0_wmask),
    .rsp0_valid (rsp0_valid),
    .rsp0_data  (rsp0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_wmask (req1_wmask),
    .rsp1_valid (rsp1_valid),
    .rsp1_data  (rsp1_data),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .R0_addr    (R0_addr),
    .R0_en      (R0_en),
    .R0_data    (R0_data),
    .W0_addr    (W0_addr),
    .W0_en      (W0_en),
    .W0_data    (W0_data),
    .W0_mask    (W0_mask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // External macro: masked write, write-first read, 1-cycle latency.
  logic [3:0] mem [128];
  logic [3:0] rd_q;
  logic [3:0] merged;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 4'hC;
  end

  assign merged = (mem[W0_addr] & ~W0_mask) | (W0_data & W0_mask);

  always @(posedge clock) begin
    if (W0_en) mem[W0_addr] <= merged;
    if (R0_en)
      rd_q <= (W0_en && W0_addr == R0_addr) ? merged : mem[R0_addr];
    else
      rd_q <= 4'bxxxx;
  end

  assign R0_data = rd_q;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv0(input logic v, input logic we,
                      input logic [6:0] a,
                      input logic [3:0] d, input logic [3:0] m);
    req0_valid = v; req0_we = we; req0_addr = a;
    req0_wdata = d; req0_wmask = m;
  endtask

  task automatic drv1(input logic v, input logic we,
                      input logic [6:0] a,
                      input logic [3:0] d, input logic [3:0] m);
    req1_valid = v; req1_we = we; req1_addr = a;
    req1_wdata = d; req1_wmask = m;
  endtask

  task automatic sweep(input int pulse_at);
    for (int k = 0; k < 128; k++) begin
      @(negedge clock);
      clear_req = (k == pulse_at);
      #1;
      chk($sformatf("sweep%0d", k),
          32'({W0_en, W0_addr, W0_data, W0_mask,
               clear_busy, R0_en, req0_ready, req1_ready}),
          32'({1'b1, 7'(k), 4'h0, 4'hF, 1'b1, 3'b000}));
    end
    @(negedge clock);
    clear_req = 1'b0;
    #1;
    chk("sweep_done_busy", 32'(clear_busy), 32'(1'b0));
  endtask

  initial begin
    reset = 1'b0;
    clear_req = 1'b0;
    drv0(1, 0, 7'd127, 0, 0);
    drv1(0, 0, 0, 0, 0);

    @(negedge clock);
    @(negedge clock);
    #1;
    chk("rst_state",
        32'({clear_busy, req0_ready, req1_ready, W0_en, R0_en,
             rsp0_valid, rsp1_valid, rsp0_data, rsp1_data}),
        32'({1'b1, 6'b0, 4'h0, 4'h0}));

    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("idle", 32'({clear_busy, W0_en, req0_ready}), 32'(3'b100));
    sweep(-1);
    chk("rd127_acc", 32'({req0_ready, req1_ready, R0_en, R0_addr}),
        32'({3'b101, 7'd127}));
    @(posedge clock); #1;
    chk("rd127_rsp", 32'({rsp0_valid, rsp0_data}), 32'({1'b1, 4'h0}));

    @(negedge clock);
    drv0(1, 1, 7'd5, 4'hA, 4'hF);
    #1;
    chk("wr5", 32'({req0_ready, W0_en, W0_addr, W0_data, W0_mask}),
        32'({2'b11, 7'd5, 4'hA, 4'hF}));
    @(negedge clock);
    drv0(1, 0, 7'd5, 0, 0);
    #1;
    chk("rd5_acc", 32'({req0_ready, R0_en, R0_addr}),
        32'({2'b11, 7'd5}));
    @(posedge clock); #1;
    chk("rd5_rsp", 32'({rsp0_valid, rsp0_data}), 32'({1'b1, 4'hA}));
    @(negedge clock);
    drv0(0, 0, 0, 0, 0);
    @(posedge clock); #1;
    chk("rsp_idle", 32'({rsp0_valid, rsp0_data, rsp1_valid}), 32'(0));

    @(negedge clock);
    drv0(1, 1, 7'd9, 4'hF, 4'h5);
    #1;
    chk("wr9m", 32'({req0_ready, W0_addr, W0_data, W0_mask}),
        32'({1'b1, 7'd9, 4'hF, 4'h5}));
    @(negedge clock);
    drv0(1, 0, 7'd9, 0, 0);
    @(posedge clock); #1;
    chk("rd9_rsp", 32'({rsp0_valid, rsp0_data}), 32'({1'b1, 4'h5}));

    @(negedge clock);
    drv0(0, 0, 0, 0, 0);
    drv1(1, 0, 7'd9, 0, 0);
    #1;
    chk("rd9_r1_acc", 32'({req0_ready, req1_ready}), 32'(2'b01));
    @(posedge clock); #1;
    chk("rd9_r1_rsp", 32'({rsp0_valid, rsp1_valid, rsp1_data}),
        32'({2'b01, 4'h5}));

    @(negedge clock);
    drv0(1, 0, 7'd5, 0, 0);
    drv1(1, 0, 7'd9, 0, 0);
    #1;
    chk("both_c1", 32'({req0_ready, req1_ready, R0_addr}),
        32'({2'b10, 7'd5}));
    @(posedge clock); #1;
    chk("both_c1_rsp", 32'({rsp0_valid, rsp0_data, rsp1_valid}),
        32'({1'b1, 4'hA, 1'b0}));
    @(negedge clock);
    drv0(0, 0, 0, 0, 0);
    #1;
    chk("both_c2", 32'({req0_ready, req1_ready, R0_addr}),
        32'({2'b01, 7'd9}));
    @(posedge clock); #1;
    chk("both_c2_rsp", 32'({rsp0_valid, rsp1_valid, rsp1_data}),
        32'({2'b01, 4'h5}));

    @(negedge clock);
    drv0(1, 1, 7'd3, 4'h6, 4'hF);
    drv1(1, 0, 7'd3, 0, 0);
    #1;
    chk("rw_same", 32'({req0_ready, req1_ready, W0_en, R0_en}),
        32'(4'hF));
    @(posedge clock); #1;
    chk("rw_same_rsp", 32'({rsp1_valid, rsp1_data}), 32'({1'b1, 4'h6}));

    @(negedge clock);
    drv0(1, 0, 7'd3, 0, 0);
    drv1(1, 1, 7'd3, 4'h9, 4'h3);
    #1;
    chk("rw_mask", 32'({req0_ready, req1_ready}), 32'(2'b11));
    @(posedge clock); #1;
    chk("rw_mask_rsp", 32'({rsp0_valid, rsp0_data}), 32'({1'b1, 4'h5}));

    @(negedge clock);
    drv0(1, 1, 7'd20, 4'h1, 4'hF);
    drv1(1, 1, 7'd21, 4'h2, 4'hF);
    #1;
    chk("ww_c1", 32'({req0_ready, req1_ready, W0_addr, W0_data}),
        32'({2'b10, 7'd20, 4'h1}));
    @(negedge clock);
    drv0(0, 0, 0, 0, 0);
    #1;
    chk("ww_c2", 32'({req0_ready, req1_ready, W0_addr, W0_data}),
        32'({2'b01, 7'd21, 4'h2}));

    @(negedge clock);
    drv0(1, 0, 7'd20, 0, 0);
    drv1(1, 0, 7'd21, 0, 0);
    #1;
    chk("rr_p1_c1", 32'({req0_ready, req1_ready, R0_addr}),
        32'({2'b01, 7'd21}));
    @(posedge clock); #1;
    chk("rr_p1_rsp1", 32'({rsp1_valid, rsp1_data, rsp0_valid}),
        32'({1'b1, 4'h2, 1'b0}));
    @(negedge clock);
    drv1(0, 0, 0, 0, 0);
    #1;
    chk("rr_p1_c2", 32'({req0_ready, R0_addr}), 32'({1'b1, 7'd20}));
    @(posedge clock); #1;
    chk("rr_p1_rsp0", 32'({rsp0_valid, rsp0_data}), 32'({1'b1, 4'h1}));

    @(negedge clock);
    drv0(0, 0, 0, 0, 0);
    drv1(1, 0, 7'd5, 0, 0);
    clear_req = 1'b1;
    #1;
    chk("clr_acc", 32'({req1_ready, clear_busy, R0_addr}),
        32'({2'b10, 7'd5}));
    @(posedge clock); #1;
    chk("clr_rsp", 32'({rsp1_valid, rsp1_data, clear_busy, req1_ready}),
        32'({1'b1, 4'hA, 2'b10}));
    sweep(60);
    chk("post_clr_acc", 32'({req1_ready, R0_addr}), 32'({1'b1, 7'd5}));
    @(posedge clock); #1;
    chk("post_clr_rsp", 32'({rsp1_valid, rsp1_data}), 32'({1'b1, 4'h0}));

    @(negedge clock);
    drv1(1, 1, 7'd7, 4'h3, 4'hF);
    #1;
    chk("wr7", 32'({req1_ready, W0_addr}), 32'({1'b1, 7'd7}));
    @(negedge clock);
    drv1(0, 0, 0, 0, 0);
    drv0(1, 0, 7'd7, 0, 0);
    #1;
    chk("rd7_acc", 32'(req0_ready), 32'(1'b1));
    #2;
    reset = 1'b0;
    #1;
    chk("rst_async", 32'({clear_busy, req0_ready, R0_en, W0_en}),
        32'(4'b1000));
    @(posedge clock); #1;
    chk("rst_drop_rsp", 32'({rsp0_valid, rsp0_data}), 32'(0));

    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("idle2", 32'({clear_busy, W0_en, req0_ready}), 32'(3'b100));
    sweep(-1);
    chk("rd7_after", 32'({req0_ready, R0_addr}), 32'({1'b1, 7'd7}));
    @(posedge clock); #1;
    chk("rd7_after_rsp", 32'({rsp0_valid, rsp0_data}),
        32'({1'b1, 4'h0}));

    @(negedge clock);
    drv0(0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
